// File: rtl/t03_nes_serial_reader.sv
// Dual NES pad reader: polls two 4021 pads, serialises 8 buttons each, presents packedOutput/confirm.
// Optional NES_MATCH_FILTER_EN: publish a frame only when it matches the previous raw frame.
module t03_nes_serial_reader #(
  parameter int unsigned POLL_CYCLES  = 166_667,
  parameter int unsigned LATCH_CYCLES = 120,
  parameter int unsigned HALF_CYCLES  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nes_data1,
  input  logic        nes_data2,
  output logic        nes_latch,
  output logic        nes_clk,
  output logic [31:0] packedOutput,
  output logic        confirm
);

  localparam int unsigned TMR_W        = $clog2(POLL_CYCLES);
  localparam int unsigned CNT_MAX      = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);
  localparam int unsigned FRAME_CYCLES = LATCH_CYCLES + 16 * HALF_CYCLES + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        pc;
  logic [1:0]        sync_a;
  logic [1:0]        sync_b;
  logic [1:0]        pressed;
  logic [7:0]        sr1;
  logic [7:0]        sr2;
  logic              poll_tick;
  logic              latch_end;
  logic              half_end;
  logic              sample;
  logic              latch_nxt;
  logic              clk_nxt;
`ifdef NES_MATCH_FILTER_EN
  logic [15:0]       prev_raw;
`endif

  assign pressed   = ~sync_b;
  assign poll_tick = (timer == TMR_W'(POLL_CYCLES - 1));
  assign latch_end = (cnt == CNT_W'(LATCH_CYCLES - 1));
  assign half_end  = (cnt == CNT_W'(HALF_CYCLES - 1));
  assign sample    = (state == LATCH && latch_end) || (state == CLK_HI && half_end && pc != 3'd7);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; ticks outside IDLE are simply not looked at
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (poll_tick) state_nxt = LATCH;
      LATCH:   if (latch_end) state_nxt = CLK_LO;
      CLK_LO:  if (half_end)  state_nxt = CLK_HI;
      CLK_HI:  if (half_end)  state_nxt = (pc == 3'd7) ? DONE : CLK_LO;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pad strobes decoded from the upcoming state so the registered pins track the state
  always_comb begin
    latch_nxt = 1'b0;
    clk_nxt   = 1'b1;
    case (state_nxt)
      LATCH:   latch_nxt = 1'b1;
      CLK_LO:  clk_nxt   = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nes_latch <= 1'b0;
      nes_clk   <= 1'b1;
    end else begin
      nes_latch <= latch_nxt;
      nes_clk   <= clk_nxt;
    end
  end

  // Timer, phase counters, synchroniser, shift registers and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer        <= '0;
      cnt          <= '0;
      pc           <= '0;
      sync_a       <= '0;
      sync_b       <= '0;
      sr1          <= '0;
      sr2          <= '0;
      packedOutput <= '0;
      confirm      <= 1'b0;
`ifdef NES_MATCH_FILTER_EN
      prev_raw     <= '0;
`endif
    end else begin
      timer   <= poll_tick ? '0 : timer + TMR_W'(1);
      sync_a  <= {nes_data2, nes_data1};
      sync_b  <= sync_a;
      confirm <= 1'b0;

      if (state_nxt != state || state == IDLE) cnt <= '0;
      else                                     cnt <= cnt + CNT_W'(1);

      if (state == LATCH)                                  pc <= '0;
      else if (state == CLK_HI && half_end && pc != 3'd7) pc <= pc + 3'd1;

      if (sample) begin
        sr1 <= {sr1[6:0], pressed[0]};
        sr2 <= {sr2[6:0], pressed[1]};
      end

      if (state == DONE) begin
`ifdef NES_MATCH_FILTER_EN
        prev_raw <= {sr1, sr2};
        if ({sr1, sr2} == prev_raw) begin
          packedOutput <= {8'h00, sr1, sr2, 8'h00};
          confirm      <= 1'b1;
        end
`else
        packedOutput <= {8'h00, sr1, sr2, 8'h00};
        confirm      <= 1'b1;
`endif
      end
    end
  end

  // A poll period no longer than one frame would silently lose polls
  frame_fits_poll: assert property (@(posedge clk) disable iff (!rst) POLL_CYCLES > FRAME_CYCLES)
    else $error("POLL_CYCLES must exceed the frame length");

endmodule

// File: tb/tb_t03_nes_serial_reader.sv
// Bench for t03_nes_serial_reader: 4021 pad models, frame-timing reference model, directed + random frames.
module tb_t03_nes_serial_reader;

  // Half-period of 3 lets the 2-flop synchroniser settle after each rising shift edge
  localparam int unsigned POLL  = 2000;
  localparam int unsigned LATCH = 4;
  localparam int unsigned HALF  = 3;
  localparam int unsigned FRAME = LATCH + 16 * HALF + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nes_data1;
  logic        nes_data2;
  logic        nes_latch;
  logic        nes_clk;
  logic [31:0] packedOutput;
  logic        confirm;

  logic [7:0]  b1 = 8'h00;
  logic [7:0]  b2 = 8'h00;
  logic [7:0]  pad1_sr = 8'hFF;
  logic [7:0]  pad2_sr = 8'hFF;

  int          vectors = 0;
  int          miscompares = 0;

  t03_nes_serial_reader #(
    .POLL_CYCLES (POLL),
    .LATCH_CYCLES(LATCH),
    .HALF_CYCLES (HALF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nes_data1   (nes_data1),
    .nes_data2   (nes_data2),
    .nes_latch   (nes_latch),
    .nes_clk     (nes_clk),
    .packedOutput(packedOutput),
    .confirm     (confirm)
  );

  always #5 clk = ~clk;

  // 4021 behaviour: parallel load while latched, shift on rising clock, active-low buttons
  always @(posedge nes_latch or posedge nes_clk) begin
    if (nes_latch) begin
      pad1_sr = ~b1;
      pad2_sr = ~b2;
    end else begin
      pad1_sr = {pad1_sr[6:0], 1'b1};
      pad2_sr = {pad2_sr[6:0], 1'b1};
    end
  end
  assign nes_data1 = pad1_sr[7];
  assign nes_data2 = pad2_sr[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clock edges since reset release decide the whole frame schedule
  int unsigned t = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) t = 0;
    else      t = t + 1;
  end

  int unsigned o;
  logic        in_frame;
  logic        e_latch, e_clk, e_conf;
  logic [7:0]  f1 = 8'h00;
  logic [7:0]  f2 = 8'h00;
  logic [15:0] prev = 16'h0;
  logic [31:0] exp_out = 32'h0;
  int          fall_cnt = 0;
  logic        clk_q = 1'b1;

  always @(negedge clk) begin
    e_conf = 1'b0;
    if (!rst) begin
      exp_out  = 32'h0;
      prev     = 16'h0;
      fall_cnt = 0;
      clk_q    = 1'b1;
      e_latch  = 1'b0;
      e_clk    = 1'b1;
    end else begin
      o        = t % POLL;
      in_frame = (t >= POLL);
      e_latch  = in_frame && (o < LATCH);
      e_clk    = !(in_frame && o >= LATCH && o < LATCH + 16 * HALF && ((o - LATCH) / HALF) % 2 == 0);
      if (in_frame && o == 0) begin
        f1 = b1;
        f2 = b2;
      end
      if (clk_q && !nes_clk) fall_cnt++;
      clk_q = nes_clk;
      if (in_frame && o == FRAME) begin
`ifdef NES_MATCH_FILTER_EN
        if ({f1, f2} == prev) begin
          e_conf  = 1'b1;
          exp_out = {8'h00, f1, f2, 8'h00};
        end
        prev = {f1, f2};
`else
        e_conf  = 1'b1;
        exp_out = {8'h00, f1, f2, 8'h00};
`endif
        check("pulses_per_frame", 32'(fall_cnt), 32'd8);
        fall_cnt = 0;
      end
    end
    check("nes_latch", 32'(nes_latch), 32'(e_latch));
    check("nes_clk", 32'(nes_clk), 32'(e_clk));
    check("confirm", 32'(confirm), 32'(e_conf));
    check("packedOutput", packedOutput, exp_out);
  end

  task automatic wait_latch(output int n);
    n = 0;
    while (!nes_latch && n < int'(POLL) + 100) begin
      @(negedge clk);
      n++;
    end
    if (!nes_latch) begin
      vectors++;
      miscompares++;
      $display("FAIL latch_timeout: actual no latch after %0d cycles required latch", n);
    end
  endtask

  // Returns at the negedge of the confirm cycle of the next frame
  task automatic frame_end();
    int n;
    wait_latch(n);
    repeat (FRAME) @(negedge clk);
  endtask

  logic [7:0] seq [6];
  logic       seq_conf [6];

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // First latch on timer wrap, all buttons released
    wait_latch(n);
    check("first_latch_cycle", 32'(n), 32'd2000);
    repeat (FRAME) @(negedge clk);
`ifndef NES_MATCH_FILTER_EN
    check("idle_pads_confirm", 32'(confirm), 32'd1);
    check("idle_pads_out", packedOutput, 32'h0000_0000);

    b1 = 8'h81; b2 = 8'h10;
    frame_end();
    check("a_right_start_confirm", 32'(confirm), 32'd1);
    check("a_right_start_out", packedOutput, 32'h0081_1000);

    b1 = 8'h08;
    frame_end();
    check("up_only_p1", 32'(packedOutput[23:16]), 32'h08);
    check("up_only_p2", 32'(packedOutput[15:8]), 32'h10);
    check("up_only_pad_bytes", {packedOutput[31:24], packedOutput[7:0]}, 32'h0);
`else
    check("filter_first_confirm", 32'(confirm), 32'd1);
    seq[0] = 8'h40; seq_conf[0] = 1'b0;
    seq[1] = 8'h40; seq_conf[1] = 1'b1;
    seq[2] = 8'h00; seq_conf[2] = 1'b0;
    seq[3] = 8'h40; seq_conf[3] = 1'b0;
    seq[4] = 8'h00; seq_conf[4] = 1'b0;
    seq[5] = 8'h40; seq_conf[5] = 1'b0;
    foreach (seq[i]) begin
      b1 = seq[i];
      frame_end();
      check("filter_confirm", 32'(confirm), 32'(seq_conf[i]));
      check("filter_out", packedOutput, (i == 0) ? 32'h0 : 32'h0040_0000);
    end
`endif

    // Random button patterns, checked by the reference model every cycle
    repeat (8) begin
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      frame_end();
    end

`ifndef NES_MATCH_FILTER_EN
    // Reset in the low phase of pulse 3 aborts the frame
    b1 = 8'h3C; b2 = 8'hC3;
    wait_latch(n);
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_latch", 32'(nes_latch), 32'd0);
    check("mid_reset_clk", 32'(nes_clk), 32'd1);
    check("mid_reset_out", packedOutput, 32'h0);
    check("mid_reset_confirm", 32'(confirm), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    frame_end();
    check("after_reset_confirm", 32'(confirm), 32'd1);
    check("after_reset_out", packedOutput, 32'h003C_C300);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
